divider_unit: RTL and testbench

DIVIDER_UNIT -- requirements
Module: divider_unit

---
 rtl/divider_unit.sv | 123 ++++++++++++
 tb/tb_divider_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/divider_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Latency DWidth+1 cycles (1 on divide-by-zero/overflow); result held in DONE until ready_i.
module divider_unit #(
    parameter  int DWidth   = 32,
    localparam int CntWidth = $clog2(DWidth) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DWidth-1:0] a_i,
    input  logic [DWidth-1:0] b_i,
    input  logic [1:0]        op_i,
    input  logic              start_i,
    output logic              ready_o,
    input  logic              kill_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DWidth-1:0] res_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CntWidth-1:0] r_cnt;
    logic [1:0]          r_op;
    logic                r_sign_a;
    logic                r_sign_b;
    logic [DWidth-1:0]   r_quo;
    logic [DWidth-1:0]   r_rem;
    logic [DWidth-1:0]   r_divisor;
    logic [DWidth-1:0]   r_res;

    logic              w_accept;
    logic              w_signed;
    logic              w_sign_a;
    logic              w_sign_b;
    logic [DWidth-1:0] w_abs_a;
    logic [DWidth-1:0] w_abs_b;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_fast;
    logic [DWidth-1:0] w_fast_res;
    logic              w_last;
    logic [DWidth:0]   w_rem_sh;
    logic [DWidth:0]   w_diff;
    logic              w_qbit;
    logic [DWidth-1:0] w_rem_nxt;
    logic [DWidth-1:0] w_quo_nxt;
    logic [DWidth-1:0] w_quo_fix;
    logic [DWidth-1:0] w_rem_fix;
    logic [DWidth-1:0] w_calc_res;

    // op_i[0] selects unsigned, op_i[1] selects remainder
    assign w_accept   = (r_state == IDLE) && start_i && !kill_i;
    assign w_signed   = ~op_i[0];
    assign w_sign_a   = w_signed & a_i[DWidth-1];
    assign w_sign_b   = w_signed & b_i[DWidth-1];
    assign w_abs_a    = w_sign_a ? -a_i : a_i;
    assign w_abs_b    = w_sign_b ? -b_i : b_i;
    assign w_div_zero = (b_i == '0);
    assign w_ovf      = w_signed && (a_i == {1'b1, {(DWidth-1){1'b0}}}) && (b_i == '1);
    assign w_fast     = w_div_zero || w_ovf;
    // On overflow the quotient equals the dividend (most negative value)
    assign w_fast_res = w_div_zero ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : a_i);

    assign w_last     = (r_cnt == CntWidth'(DWidth - 1));
    assign w_rem_sh   = {r_rem, r_quo[DWidth-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_divisor};
    assign w_qbit     = ~w_diff[DWidth];
    assign w_rem_nxt  = w_qbit ? w_diff[DWidth-1:0] : w_rem_sh[DWidth-1:0];
    assign w_quo_nxt  = {r_quo[DWidth-2:0], w_qbit};
    assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_fix  = r_sign_a ? -w_rem_nxt : w_rem_nxt;
    assign w_calc_res = r_op[1] ? w_rem_fix : w_quo_fix;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = w_fast ? DONE : CALC;
            CALC: if (w_last) w_state_nxt = DONE;
            DONE: if (ready_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (kill_i) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_res     <= '0;
            r_op      <= '0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op      <= op_i;
                r_sign_a  <= w_sign_a;
                r_sign_b  <= w_sign_b;
                r_quo     <= w_abs_a;
                r_divisor <= w_abs_b;
                r_rem     <= '0;
                r_cnt     <= '0;
                if (w_fast) r_res <= w_fast_res;
            end else if (r_state == CALC) begin
                r_quo <= w_quo_nxt;
                r_rem <= w_rem_nxt;
                r_cnt <= r_cnt + CntWidth'(1);
                // A flush on the final iteration must not disturb the held result
                if (w_last && !kill_i) r_res <= w_calc_res;
            end
        end
    end

    assign ready_o = (r_state == IDLE);
    assign valid_o = (r_state == DONE);
    assign res_o   = r_res;

endmodule

// File: tb/tb_divider_unit.sv
// Directed-vector bench for divider_unit: latency, signed/unsigned results, fast paths,
// backpressure hold, kill and mid-operation reset.
module tb_divider_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [1:0]  op_i;
    logic        start_i;
    logic        ready_o;
    logic        kill_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] res_o;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    divider_unit #(.DWidth(32)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .op_i    (op_i),
        .start_i (start_i),
        .ready_o (ready_o),
        .kill_i  (kill_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .res_o   (res_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present an op in cycle 0 with ready_i=1; expect valid_o in cycle exp_lat, then IDLE.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int n;
        @(negedge clk_i);
        check_val({tag, "_rdy"}, ready_o, 1);
        a_i = a; b_i = b; op_i = op; start_i = 1'b1; ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        n = 1;
        while (!valid_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check_val({tag, "_lat"}, n, exp_lat);
        check_val({tag, "_res"}, res_o, exp);
        @(negedge clk_i);
        check_val({tag, "_idle"}, ready_o, 1);
    endtask

    initial begin
        int seen_vld;
        rst_i = 1'b1; a_i = '0; b_i = '0; op_i = '0; start_i = 1'b0; kill_i = 1'b0; ready_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check_val("rst_res", res_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check_val("rst_rdy", ready_o, 1);
        check_val("rst_vld", valid_o, 0);

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("div_7_m2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_7_m2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_op("divu_max_3", OP_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 33);
        run_op("divu_5_0",   OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_5_0",   OP_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_m5_0",   OP_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("divu_nofast", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

        // Kill mid-calculation with a simultaneous start
        @(negedge clk_i);
        a_i = 32'd1000; b_i = 32'd3; op_i = OP_DIVU; start_i = 1'b1; ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        kill_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0; start_i = 1'b0;
        check_val("kill_rdy", ready_o, 1);
        check_val("kill_vld", valid_o, 0);
        kill_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0; start_i = 1'b0;
        check_val("kill_start_idle", ready_o, 1);
        seen_vld = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (valid_o) seen_vld = 1;
        end
        check_val("kill_no_vld", seen_vld, 0);

        // Backpressure: result held from cycle 33 to 40
        @(negedge clk_i);
        a_i = 32'd1000; b_i = 32'd10; op_i = OP_DIVU; start_i = 1'b1; ready_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (31) @(negedge clk_i);
        check_val("hold_c32_vld", valid_o, 0);
        for (int c = 33; c <= 40; c++) begin
            @(negedge clk_i);
            if (c == 40) ready_i = 1'b1;
            check_val($sformatf("hold_c%0d_vld", c), valid_o, 1);
            check_val($sformatf("hold_c%0d_res", c), res_o, 100);
        end
        @(negedge clk_i);
        ready_i = 1'b0;
        check_val("hold_c41_rdy", ready_o, 1);
        check_val("hold_c41_vld", valid_o, 0);

        // Reset in cycle 5 of a new op
        @(negedge clk_i);
        a_i = 32'd77; b_i = 32'd5; op_i = OP_DIVU; start_i = 1'b1; ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check_val("rstmid_busy", ready_o, 0);
        rst_i = 1'b1; kill_i = 1'b0; start_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0; start_i = 1'b0;
        check_val("rstmid_rdy", ready_o, 1);
        check_val("rstmid_vld", valid_o, 0);
        check_val("rstmid_res", res_o, 0);
        seen_vld = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (valid_o) seen_vld = 1;
        end
        check_val("rstmid_no_vld", seen_vld, 0);

        run_op("post_rst_divu", OP_DIVU, 32'd77, 32'd5, 32'd15, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
